// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin scheduler in front of a shared
// add/sub/compare unit. Accepted operands are registered, then the result and
// C/Z/N/O flags are computed and returned on one tagged response channel.
// Optional feature macro: ALU_SCHED_FLAGREG_EN builds the architectural flags
// register behind flags_q. Without it, flags_q is tied to zero.
module alu_sched #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [3:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_c,
    output logic               rsp_z,
    output logic               rsp_n,
    output logic               rsp_o,
    output logic [3:0]         flags_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_CMP  = 2'b10,
        OP_PASS = 2'b11
    } op_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant;
    logic             accept;

    op_t              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;

    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   sum;
    logic             sub;
    logic             sb;
    logic [WIDTH-1:0] res_nxt;
    logic             c_nxt;
    logic             z_nxt;
    logic             n_nxt;
    logic             o_nxt;

    // Round-robin pick: a sole requester wins, a tie goes to the one not granted last
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and request handshake; ready is held low while reset is asserted
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (reset_n && req_valid[grant]) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);

    // Capture the granted requester's operation and the new last-grant pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
        end else if (accept) begin
            last_grant <= grant;
            op_q       <= op_t'(grant ? req_op[3:2] : req_op[1:0]);
            a_q        <= grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            b_q        <= grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            id_q       <= grant;
        end
    end

    // ALU datapath: 17-bit add/subtract with carry/borrow in the top bit
    always_comb begin
        sub     = (op_q == OP_SUB) || (op_q == OP_CMP);
        a_ext   = {1'b0, a_q};
        b_ext   = {1'b0, b_q};
        sum     = sub ? (a_ext - b_ext) : (a_ext + b_ext);
        sb      = sub ^ b_q[WIDTH-1];
        res_nxt = (op_q == OP_CMP) ? a_q : sum[WIDTH-1:0];
        c_nxt   = sum[WIDTH];
        z_nxt   = (sum[WIDTH-1:0] == '0);
        n_nxt   = sum[WIDTH-1];
        o_nxt   = (sum[WIDTH-1] & ~a_q[WIDTH-1] & ~sb) |
                  (~sum[WIDTH-1] & a_q[WIDTH-1] & sb);
        if (op_q == OP_PASS) begin
            res_nxt = b_q;
            c_nxt   = 1'b0;
            z_nxt   = (b_q == '0);
            n_nxt   = b_q[WIDTH-1];
            o_nxt   = 1'b0;
        end
    end

    // Response registers: loaded in EXEC, held through RESP and beyond
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_c      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_o      <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id     <= id_q;
            rsp_result <= res_nxt;
            rsp_c      <= c_nxt;
            rsp_z      <= z_nxt;
            rsp_n      <= n_nxt;
            rsp_o      <= o_nxt;
        end
    end

`ifdef ALU_SCHED_FLAGREG_EN
    // Architectural flags {C,Z,N,O}: updated by arithmetic ops, PASS leaves them alone
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if ((state == EXEC) && (op_q != OP_PASS)) begin
            flags_q <= {c_nxt, z_nxt, n_nxt, o_nxt};
        end
    end
`else
    assign flags_q = '0;
`endif

endmodule
